// File: rtl/priority_arbiter_ctrl.sv
// Four-requester access controller with fixed or rotating priority, hold timeout
// and fully registered grant outputs.
module priority_arbiter_ctrl #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_req,
    input  logic       i_rr_en,
    input  logic       i_release,
    output logic [3:0] o_gnt,
    output logic [1:0] o_gnt_id,
    output logic       o_gnt_vld,
    output logic       o_timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            r_state;
    logic [HOLD_W-1:0] r_hold;
    logic [1:0]        r_ptr;
    logic [3:0]        r_gnt;
    logic [1:0]        r_gnt_id;
    logic              r_gnt_vld;
    logic              r_timeout;

    logic [1:0]        w_win_id;
    logic [1:0]        w_idx;
    logic              w_win_any;
    logic              w_owner_drop;

    // Winner selection; the last matching assignment in each loop is the highest priority.
    always_comb begin
        w_win_id     = 2'd0;
        w_idx        = 2'd0;
        w_win_any    = |i_req;
        w_owner_drop = ~i_req[r_gnt_id];
        if (i_rr_en) begin
            for (int k = 3; k >= 0; k--) begin
                w_idx    = r_ptr - 2'(k);
                w_win_id = i_req[w_idx] ? w_idx : w_win_id;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                w_win_id = i_req[k] ? 2'(k) : w_win_id;
            end
        end
    end

    // Arbitration state machine with registered grant, hold counter and timeout pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_hold    <= {HOLD_W{1'b0}};
            r_ptr     <= 2'd3;
            r_gnt     <= 4'b0000;
            r_gnt_id  <= 2'd0;
            r_gnt_vld <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_timeout <= 1'b0;
                    if (w_win_any) begin
                        r_gnt     <= 4'b0001 << w_win_id;
                        r_gnt_id  <= w_win_id;
                        r_gnt_vld <= 1'b1;
                        r_hold    <= {HOLD_W{1'b0}};
                        r_state   <= ST_GRANT;
                        if (i_rr_en) begin
                            r_ptr <= w_win_id - 2'd1;
                        end else begin
                            r_ptr <= r_ptr;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (i_release || w_owner_drop || (r_hold == HOLD_LAST)) begin
                        // A voluntary exit on the last hold cycle is not a revocation.
                        r_timeout <= ~i_release & ~w_owner_drop;
                        r_gnt     <= 4'b0000;
                        r_gnt_id  <= 2'd0;
                        r_gnt_vld <= 1'b0;
                        r_hold    <= {HOLD_W{1'b0}};
                        r_state   <= ST_IDLE;
                    end else begin
                        r_timeout <= 1'b0;
                        r_hold    <= r_hold + {{(HOLD_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_gnt     <= 4'b0000;
                    r_gnt_id  <= 2'd0;
                    r_gnt_vld <= 1'b0;
                    r_timeout <= 1'b0;
                    r_hold    <= {HOLD_W{1'b0}};
                end
            endcase
        end
    end

    assign o_gnt     = r_gnt;
    assign o_gnt_id  = r_gnt_id;
    assign o_gnt_vld = r_gnt_vld;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_priority_arbiter_ctrl.sv
// Self-checking bench for priority_arbiter_ctrl: directed vector table, corner-case
// sequences and a randomized run against a cycle-level behavioural model.
module tb_priority_arbiter_ctrl;

    localparam int MAX_HOLD = 16;
    localparam int HOLD_W   = 5;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic       rr_en = 1'b0;
    logic       rel   = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: owner index (-1 when idle), cycles the owner has seen gnt, rotation pointer.
    int   m_owner;
    int   m_cnt;
    int   m_ptr;
    logic m_to;

    typedef struct {
        logic [3:0] req;
        logic       rr;
        logic       rel;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       vld;
        logic       to;
    } vec_t;

    vec_t tbl [15];

    always #5 clk = ~clk;

    priority_arbiter_ctrl #(.MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_rr_en   (rr_en),
        .i_release (rel),
        .o_gnt     (gnt),
        .o_gnt_id  (gnt_id),
        .o_gnt_vld (gnt_vld),
        .o_timeout (timeout)
    );

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 3;
        m_to    = 1'b0;
    endtask

    function automatic int pick_winner();
        int w = -1;
        if (rr_en) begin
            for (int k = 0; k < 4; k++) begin
                int idx = (m_ptr + 4 - k) % 4;
                if (req[idx]) begin
                    w = idx;
                    break;
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (req[i]) w = i;
            end
        end
        return w;
    endfunction

    task automatic model_update();
        int w;
        if (m_owner < 0) begin
            m_to = 1'b0;
            w = pick_winner();
            if (w >= 0) begin
                m_owner = w;
                m_cnt   = 1;
                if (rr_en) m_ptr = (w + 3) % 4;
            end
        end else if (rel || !req[m_owner]) begin
            m_owner = -1;
            m_to    = 1'b0;
        end else if (m_cnt == MAX_HOLD) begin
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_cnt++;
            m_to = 1'b0;
        end
    endtask

    task automatic check_model();
        check("model_gnt", int'(gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
        check("model_gnt_id", int'(gnt_id), (m_owner >= 0) ? m_owner : 0);
        check("model_gnt_vld", int'(gnt_vld), (m_owner >= 0) ? 1 : 0);
        check("model_timeout", int'(timeout), int'(m_to));
    endtask

    task automatic step(input logic [3:0] r, input logic rr, input logic rl);
        req   = r;
        rr_en = rr;
        rel   = rl;
        @(posedge clk);
        #1;
        model_update();
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        rr_en = 1'b0;
        rel   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_gnt", int'(gnt), 0);
        check("reset_gnt_id", int'(gnt_id), 0);
        check("reset_gnt_vld", int'(gnt_vld), 0);
        check("reset_timeout", int'(timeout), 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        tbl[0]  = '{4'b0110, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[1]  = '{4'b0110, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{4'b0110, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[3]  = '{4'b0110, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[4]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[5]  = '{4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[6]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[7]  = '{4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[8]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[9]  = '{4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[10] = '{4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[11] = '{4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[12] = '{4'b1111, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[13] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[14] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};

        // Fixed priority, release, then rotating fairness 3,2,1,0,3.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].req, tbl[i].rr, tbl[i].rel);
            check($sformatf("tbl%0d_gnt", i), int'(gnt), int'(tbl[i].gnt));
            check($sformatf("tbl%0d_gnt_id", i), int'(gnt_id), int'(tbl[i].id));
            check($sformatf("tbl%0d_gnt_vld", i), int'(gnt_vld), int'(tbl[i].vld));
            check($sformatf("tbl%0d_timeout", i), int'(timeout), int'(tbl[i].to));
        end

        // Timeout: held for exactly MAX_HOLD cycles, one-cycle pulse, then regrant.
        do_reset();
        step(4'b0001, 1'b0, 1'b0);
        check("to_first_gnt", int'(gnt), 1);
        for (int c = 2; c <= MAX_HOLD; c++) begin
            step(4'b0001, 1'b0, 1'b0);
            check($sformatf("to_hold%0d_gnt", c), int'(gnt), 1);
            check($sformatf("to_hold%0d_timeout", c), int'(timeout), 0);
        end
        step(4'b0001, 1'b0, 1'b0);
        check("to_revoke_gnt", int'(gnt), 0);
        check("to_revoke_vld", int'(gnt_vld), 0);
        check("to_pulse", int'(timeout), 1);
        step(4'b0001, 1'b0, 1'b0);
        check("to_regrant_gnt", int'(gnt), 1);
        check("to_pulse_end", int'(timeout), 0);

        // Release on the final hold cycle wins over the timeout.
        for (int c = 2; c <= MAX_HOLD; c++) step(4'b0001, 1'b0, 1'b0);
        check("coll_hold16_gnt", int'(gnt), 1);
        step(4'b0001, 1'b0, 1'b1);
        check("coll_gnt", int'(gnt), 0);
        check("coll_timeout", int'(timeout), 0);

        // Owner drop returns to IDLE, then the remaining requester is granted.
        do_reset();
        step(4'b1000, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        check("drop_owner", int'(gnt_id), 3);
        step(4'b0011, 1'b0, 1'b0);
        check("drop_idle", int'(gnt_vld), 0);
        check("drop_timeout", int'(timeout), 0);
        step(4'b0011, 1'b0, 1'b0);
        check("drop_next_id", int'(gnt_id), 1);

        // Asynchronous reset mid-grant; pointer must restart at 3.
        step(4'b0000, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b0);
        check("arst_pre_id", int'(gnt_id), 3);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_gnt", int'(gnt), 0);
        check("arst_gnt_id", int'(gnt_id), 0);
        check("arst_gnt_vld", int'(gnt_vld), 0);
        check("arst_timeout", int'(timeout), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(4'b1001, 1'b1, 1'b0);
        check("arst_ptr3_id", int'(gnt_id), 3);

        // Randomized traffic with sticky requests so holds reach the timeout.
        do_reset();
        begin
            logic [3:0] r  = 4'b0000;
            logic       rr = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 5) == 0) r  = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 9) == 0) rr = 1'($urandom_range(0, 1));
                step(r, rr, ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/priority_arbiter_ctrl.md
# priority_arbiter_ctrl

Sequential arbiter that shares one resource among four requesters using the 4-bit priority-encoding rule: highest index wins in fixed mode. A selectable rotating mode gives round-robin fairness. Each grant is held until the owner releases it, drops its request, or hits a hold timeout. All outputs are registered, so the block drops directly in front of a shared datapath as its access controller.

## Interface
- MAX_HOLD, 16: maximum cycles a grant may be held before forced revocation (legal range 1..2^HOLD_W-1)
- HOLD_W, 5: width of the hold counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset; one clock, reset asynchronous active-low
- req  input  4  request vector, bit i = requester i
- rr_en  input  1  1 = rotating priority, 0 = fixed priority (bit 3 highest)
- release  input  1  current owner finished; ends grant
- gnt  output  4  one-hot grant, registered
- gnt_id  output  2  binary index of granted requester, 0 when gnt_vld=0
- gnt_vld  output  1  a grant is active (OR of gnt)
- timeout  output  1  single-cycle pulse when a grant is revoked by MAX_HOLD

## Operation
- States: IDLE, GRANT.
- Reset (async, rst_n=0):
  - state=IDLE; gnt=0, gnt_id=0, gnt_vld=0, timeout=0.
  - hold counter=0; rotation pointer ptr=3.
- IDLE:
  - If req≠0, pick a winner, load gnt/gnt_id/gnt_vld, clear hold counter, go to GRANT.
  - If req=0, stay in IDLE.
  - release is ignored in IDLE.
- Arbitration, fixed mode (rr_en=0): winner is the highest set index of req (3 > 2 > 1 > 0).
- Arbitration, rotating mode (rr_en=1):
  - Search order is ptr, ptr-1, ptr-2, ptr-3 (mod 4); the first set bit wins.
  - After granting index j, ptr := (j-1) mod 4, so the last winner becomes lowest priority.
  - ptr updates only on a grant in rotating mode; it holds its value in fixed mode.
- rr_en is sampled only at arbitration decisions. Changing it mid-grant does not affect the current owner.
- GRANT: the hold counter increments every cycle. Exit to IDLE on the first cycle any of the following is true:
  - release=1.
  - req[gnt_id]=0 (owner dropped its request).
  - Hold counter = MAX_HOLD-1. This is a timeout: timeout=1 for exactly one cycle, coincident with the first IDLE cycle.
- Exit clears gnt, gnt_id and gnt_vld. IDLE always lasts at least one cycle between grants, so grants never overlap and there is no back-to-back handoff.
- Simultaneous exit causes (release and timeout on the same cycle): release takes precedence and timeout stays 0.
- A timed-out requester is eligible again at the next arbitration:
  - Fixed mode: it can win again if it is still highest.
  - Rotating mode: it drops to lowest priority.
- Requests from non-owners during GRANT are ignored until the next arbitration.

## Timing
- Grant latency: a req sampled at edge k produces gnt at the output after edge k (visible during cycle k+1).
- Release latency: release=1 sampled at edge m gives gnt=0 after edge m. The earliest next grant is after edge m+1.
- Max hold: the owner sees gnt for exactly MAX_HOLD cycles if it never releases.
- Re-arbitration period under continuous requests: MAX_HOLD+1 cycles (MAX_HOLD granted plus 1 IDLE).
- Reset mid-grant: outputs clear immediately on rst_n fall, without waiting for a clock. The first grant after deassertion takes one full edge.
- gnt, gnt_id and gnt_vld are always mutually consistent. There are no combinational paths from inputs to outputs.

## Test plan
- Reset and fixed priority:
  - Reset, then rr_en=0, req=4'b0110 -> after 1 edge gnt=4'b0100, gnt_id=2, gnt_vld=1.
  - Pulse release -> gnt=0 for one cycle, then gnt=4'b0100 again.
- Rotating fairness:
  - rr_en=1, req=4'b1111 held, release pulsed on each grant's first cycle -> grant sequence 3,2,1,0,3 with an IDLE cycle between each grant.
- Timeout (MAX_HOLD=16):
  - req=4'b0001, never release -> gnt=4'b0001 for 16 cycles.
  - Then gnt=0 with timeout=1 for 1 cycle, then regrant to 0.
- Owner drop:
  - While owner 3 is held, deassert req[3] with req=4'b0011 -> next cycle IDLE, following cycle gnt_id=1.
- Release/timeout collision:
  - Assert release on hold cycle 16 -> gnt clears, timeout stays 0.
- Async reset mid-grant:
  - Assert rst_n=0 between clock edges during GRANT -> gnt, gnt_id, gnt_vld and timeout are all 0 immediately.
  - After release of reset, rotating mode restarts with ptr=3: req=4'b1001 -> gnt_id=3.
